// File: rtl/lcb_word_assembler.sv
// Pairs LCB response bytes into 12-bit words, routes them to fast/slow paths, closes packets on line-idle timeout.
// Word pulse 1 clk after low-byte strobe; close pulse GAP_CYC+1 clks after last strobe; no backpressure (FIFOs must accept).
module lcb_word_assembler #(
  parameter int BYTES      = 16,
  parameter int FAST_WORDS = 4,
  parameter int GAP_CYC    = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  iData,
  input  logic        strob,
  input  logic [10:0] sAddr,
  output logic [11:0] fData,
  output logic        fVal,
  output logic [11:0] sData,
  output logic        sVal,
  output logic [10:0] sWrAddr,
  output logic        pktDone,
  output logic        pktErr,
  output logic [7:0]  errCnt
);

  localparam int          GW       = $clog2(GAP_CYC + 1);
  localparam logic [4:0]  BYTES_C  = 5'(BYTES);
  localparam logic [4:0]  FAST_C   = 5'(FAST_WORDS);
  localparam logic [10:0] FAST_A   = 11'(FAST_WORDS);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    hi_q, hi_d;
  logic [10:0]   base_q, base_d;
  logic [11:0]   f_dat_q, f_dat_d;
  logic          f_vld_q, f_vld_d;
  logic [11:0]   s_dat_q, s_dat_d;
  logic          s_vld_q, s_vld_d;
  logic [10:0]   s_addr_q, s_addr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic [3:0]    widx;
  logic [11:0]   word;

  assign widx = cnt_q[4:1];
  assign word = {hi_q, iData};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      hi_q      <= '0;
      base_q    <= '0;
      f_dat_q   <= '0;
      f_vld_q   <= 1'b0;
      s_dat_q   <= '0;
      s_vld_q   <= 1'b0;
      s_addr_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      hi_q      <= hi_d;
      base_q    <= base_d;
      f_dat_q   <= f_dat_d;
      f_vld_q   <= f_vld_d;
      s_dat_q   <= s_dat_d;
      s_vld_q   <= s_vld_d;
      s_addr_q  <= s_addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    hi_d      = hi_q;
    base_d    = base_q;
    f_dat_d   = f_dat_q;
    f_vld_d   = 1'b0;
    s_dat_d   = s_dat_q;
    s_vld_d   = 1'b0;
    s_addr_d  = s_addr_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (strob) begin
          state_d = COLLECT;
          base_d  = sAddr;
          cnt_d   = 5'd1;
          hi_d    = iData[3:0];
          gap_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      COLLECT: begin
        if (strob) begin
          // A strobe always beats timer expiry in the same cycle.
          gap_d = '0;
          if (cnt_q == BYTES_C) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
            if (!cnt_q[0]) begin
              hi_d = iData[3:0];
            end else if ({1'b0, widx} < FAST_C) begin
              f_dat_d = word;
              f_vld_d = 1'b1;
            end else begin
              s_dat_d  = word;
              s_vld_d  = 1'b1;
              s_addr_d = base_q + (11'(widx) - FAST_A);
            end
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          if (cnt_q == BYTES_C && !ovf_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fData   = f_dat_q;
  assign fVal    = f_vld_q;
  assign sData   = s_dat_q;
  assign sVal    = s_vld_q;
  assign sWrAddr = s_addr_q;
  assign pktDone = done_q;
  assign pktErr  = err_q;
  assign errCnt  = err_cnt_q;

endmodule

// File: tb/tb_lcb_word_assembler.sv
// Scoreboarded bench: table of packet cases plus hand sequences for gap boundary, reset and error saturation.
module tb_lcb_word_assembler;

  localparam int BYTES = 16;
  localparam int FAST  = 4;
  localparam int GAP   = 400;
  localparam int SGAP  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  iData;
  logic        strob;
  logic [10:0] sAddr;
  logic [11:0] fData, sData;
  logic        fVal, sVal, pktDone, pktErr;
  logic [10:0] sWrAddr;
  logic [7:0]  errCnt;

  logic [7:0]  s_iData;
  logic        s_strob;
  logic [11:0] s_fData, s_sData;
  logic        s_fVal, s_sVal, s_pktDone, s_pktErr;
  logic [10:0] s_sWrAddr;
  logic [7:0]  s_errCnt;

  always #5 clk = ~clk;

  lcb_word_assembler #(.BYTES(BYTES), .FAST_WORDS(FAST), .GAP_CYC(GAP)) u_dut (
    .clk(clk), .rst(rst), .iData(iData), .strob(strob), .sAddr(sAddr),
    .fData(fData), .fVal(fVal), .sData(sData), .sVal(sVal), .sWrAddr(sWrAddr),
    .pktDone(pktDone), .pktErr(pktErr), .errCnt(errCnt));

  lcb_word_assembler #(.BYTES(BYTES), .FAST_WORDS(FAST), .GAP_CYC(SGAP)) u_sat (
    .clk(clk), .rst(rst), .iData(s_iData), .strob(s_strob), .sAddr(11'd0),
    .fData(s_fData), .fVal(s_fVal), .sData(s_sData), .sVal(s_sVal), .sWrAddr(s_sWrAddr),
    .pktDone(s_pktDone), .pktErr(s_pktErr), .errCnt(s_errCnt));

  typedef struct {
    logic [11:0] d;
    logic [10:0] a;
    longint      cyc;
  } word_t;

  typedef struct {
    bit     ok;
    longint cyc;
  } close_t;

  typedef struct {
    int          n;
    logic [10:0] sa;
    int          sp;
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          ok;
    logic [7:0]  err;
    int          nw;
    logic [11:0] w0;
    logic [10:0] last_a;
  } vec_t;

  word_t  fq[$];
  word_t  sq[$];
  close_t cq[$];

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     nw_seen;
  logic [11:0] first_w;
  logic [10:0] last_a;
  int     sat_errs = 0;

  logic [7:0] pb[32];
  int         pg[32];
  vec_t       vt[6];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      word_t  w;
      close_t c;
      if (fVal && sVal) chk("fval_sval_excl", 1, 0);
      if (pktDone && pktErr) chk("done_err_excl", 1, 0);
      if (fVal) begin
        if (fq.size() == 0) chk("fast_unexpected", 1, 0);
        else begin
          w = fq.pop_front();
          chk("fast_dat", fData, w.d);
          chk("fast_cyc", cyc, w.cyc);
        end
        if (nw_seen == 0) first_w = fData;
        nw_seen++;
      end
      if (sVal) begin
        if (sq.size() == 0) chk("slow_unexpected", 1, 0);
        else begin
          w = sq.pop_front();
          chk("slow_dat", sData, w.d);
          chk("slow_addr", sWrAddr, w.a);
          chk("slow_cyc", cyc, w.cyc);
        end
        if (nw_seen == 0) first_w = sData;
        last_a = sWrAddr;
        nw_seen++;
      end
      if (pktDone || pktErr) begin
        if (cq.size() == 0) chk("close_unexpected", 1, 0);
        else begin
          c = cq.pop_front();
          chk("close_kind_done", pktDone, c.ok);
          chk("close_cyc", cyc, c.cyc);
        end
      end
      if (s_pktErr) sat_errs++;
      if (s_fVal || s_sVal || s_pktDone) chk("sat_unexpected_pulse", 1, 0);
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic strobe_byte(input logic [7:0] b);
    iData = b;
    strob = 1'b1;
    @(posedge clk);
    #1;
    strob = 1'b0;
  endtask

  task automatic fill_pattern(input int n, input int sp);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) pb[i] = 8'(i / 2 + 1);
      else            pb[i] = {4'(i / 2 + 2), 4'(i / 2 + 3)};
      pg[i] = sp - 1;
    end
    pg[n-1] = 0;
  endtask

  // Expected words and close event are pushed as each byte is driven.
  task automatic run_pkt(input int n, input logic [10:0] sa, input bit ok,
                         input bit do_close, input bit wait_close);
    longint t;
    int w;
    word_t e;
    close_t c;
    sAddr = sa;
    for (int i = 0; i < n; i++) begin
      t = cyc;
      if (i % 2 == 1 && i < BYTES) begin
        w   = i / 2;
        e.d = {pb[i-1][3:0], pb[i]};
        e.cyc = t + 1;
        if (w < FAST) begin
          e.a = '0;
          fq.push_back(e);
        end else begin
          e.a = 11'(sa + 11'(w - FAST));
          sq.push_back(e);
        end
      end
      if (i == n - 1 && do_close) begin
        c.ok  = ok;
        c.cyc = t + GAP + 1;
        cq.push_back(c);
      end
      strobe_byte(pb[i]);
      idle(pg[i]);
    end
    if (wait_close) begin
      for (int k = 0; k < 2 * GAP + 50 && cq.size() != 0; k++) idle(1);
      chk("close_seen", cq.size(), 0);
    end
  endtask

  initial begin
    vt[0] = '{n:16, sa:11'd100,  sp:167, b0:8'h01, b1:8'h23, ok:1, err:8'd0, nw:8, w0:12'h123, last_a:11'd103};
    vt[1] = '{n:16, sa:11'd100,  sp:5,   b0:8'hF5, b1:8'hAA, ok:1, err:8'd0, nw:8, w0:12'h5AA, last_a:11'd103};
    vt[2] = '{n:10, sa:11'd100,  sp:3,   b0:8'h01, b1:8'h23, ok:0, err:8'd1, nw:5, w0:12'h123, last_a:11'd100};
    vt[3] = '{n:18, sa:11'd200,  sp:3,   b0:8'h01, b1:8'h23, ok:0, err:8'd2, nw:8, w0:12'h123, last_a:11'd203};
    vt[4] = '{n:16, sa:11'd2046, sp:2,   b0:8'h01, b1:8'h23, ok:1, err:8'd2, nw:8, w0:12'h123, last_a:11'd1};
    vt[5] = '{n:1,  sa:11'd0,    sp:1,   b0:8'h07, b1:8'h00, ok:0, err:8'd3, nw:0, w0:12'h000, last_a:11'd0};

    rst = 1'b1; strob = 1'b0; iData = '0; sAddr = '0; s_strob = 1'b0; s_iData = '0;
    nw_seen = 0; first_w = '0; last_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {fData, fVal, sData, sVal, sWrAddr, pktDone, pktErr, errCnt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    for (int r = 0; r < 6; r++) begin
      fill_pattern(vt[r].n, vt[r].sp);
      pb[0] = vt[r].b0;
      if (vt[r].n > 1) pb[1] = vt[r].b1;
      nw_seen = 0;
      run_pkt(vt[r].n, vt[r].sa, vt[r].ok, 1'b1, 1'b1);
      chk($sformatf("row%0d_nwords", r), nw_seen, vt[r].nw);
      chk($sformatf("row%0d_errcnt", r), errCnt, vt[r].err);
      if (vt[r].nw > 0)    chk($sformatf("row%0d_word0", r), first_w, vt[r].w0);
      if (vt[r].nw > FAST) chk($sformatf("row%0d_last_addr", r), last_a, vt[r].last_a);
      idle(3);
    end

    // idle of GAP-1 cycles mid-packet: the strobe lands on the expiry cycle
    fill_pattern(16, 1);
    pg[7] = GAP - 1;
    nw_seen = 0;
    run_pkt(16, 11'd50, 1'b1, 1'b1, 1'b1);
    chk("gap_m1_nwords", nw_seen, 8);
    chk("gap_m1_errcnt", errCnt, 3);

    // idle of GAP cycles splits into two short packets
    fill_pattern(8, 2);
    pg[7] = GAP;
    run_pkt(8, 11'd300, 1'b0, 1'b1, 1'b0);
    fill_pattern(8, 2);
    run_pkt(8, 11'd300, 1'b0, 1'b1, 1'b1);
    chk("gap_split_errcnt", errCnt, 5);
    idle(3);

    // reset after 7 bytes of an open packet
    fill_pattern(7, 2);
    run_pkt(7, 11'd100, 1'b0, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {fData, fVal, sData, sVal, sWrAddr, pktDone, pktErr}, 0);
    chk("midrst_errcnt", errCnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(GAP + 20);
    chk("midrst_no_close", fq.size() + sq.size() + cq.size(), 0);
    fill_pattern(16, 2);
    run_pkt(16, 11'd100, 1'b1, 1'b1, 1'b1);
    chk("after_rst_errcnt", errCnt, 0);

    // errCnt saturation on the short-gap instance
    for (int k = 1; k <= 260; k++) begin
      s_iData = 8'(k);
      s_strob = 1'b1;
      idle(1);
      s_strob = 1'b0;
      idle(SGAP + 4);
      if (k == 254) chk("sat_errcnt_254", s_errCnt, 254);
    end
    chk("sat_errcnt_260", s_errCnt, 255);
    chk("sat_err_pulses", sat_errs, 260);
    chk("sat_no_words", {s_fData, s_sData, s_sWrAddr}, 0);
    chk("queues_drained", fq.size() + sq.size() + cq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcb_word_assembler.md
# lcb_word_assembler

Receive-side word assembler between a UART receiver (`uartRx`) and the fast/slow FIFO pair that feeds the frame packer. It takes the byte stream returned by one LCB over RS-485, finds packet boundaries by line-idle timeout, and pairs bytes into 12-bit telemetry words. It routes the first `FAST_WORDS` words of each packet to the fast path and the remainder to the slow path, tagging each slow word with its orbital-RAM address. It also reports packet completion, length errors and a saturating error count.

## Interface
- `BYTES`, 16: expected bytes per LCB response packet; even, 2..30.
- `FAST_WORDS`, 4: words per packet routed to the fast path; 0..`BYTES`/2.
- `GAP_CYC`, 400: idle clocks after the last byte that close a packet (about 2.4 byte times at 4.8 Mbaud and 80 MHz).

- `clk` in 1: system clock (clk80MHz domain).
- `rst` in 1: reset, asynchronous, active-high.
- `iData` in 8: received byte; valid only while `strob` is high.
- `strob` in 1: one-cycle byte-valid pulse from the receiver.
- `sAddr` in 11: slow-word base RAM address from the request ROM; sampled on the first byte of a packet.
- `fData` out 12: fast word.
- `fVal` out 1: one-cycle pulse, `fData` valid (FIFO wrreq).
- `sData` out 12: slow word.
- `sVal` out 1: one-cycle pulse, `sData` and `sWrAddr` valid.
- `sWrAddr` out 11: RAM address of the current slow word.
- `pktDone` out 1: one-cycle pulse, packet closed with exactly `BYTES` bytes.
- `pktErr` out 1: one-cycle pulse, packet closed with a wrong length.
- `errCnt` out 8: count of `pktErr` events, saturating at 255.

## Operation
- There are two states.
  - IDLE: no packet is open.
  - COLLECT: a packet is open.
- IDLE -> COLLECT on `strob`. On that transition:
  - `sAddr` is latched into `baseAddr`.
  - The byte counter is set to 1.
  - The byte is stored as the high byte.
  - The gap timer is cleared.
- In COLLECT, every `strob` clears the gap timer.
- In COLLECT, if no `strob` arrives, the gap timer increments each cycle. When it reaches `GAP_CYC`, the packet closes and the block returns to IDLE.
- Byte pairing:
  - An even byte index (0, 2, …) is the high byte; only its bits [3:0] are used.
  - An odd byte index is the low byte. Word = {hi[3:0], lo[7:0]}.
  - Word index w = byte index >> 1.
- Routing:
  - w < `FAST_WORDS`: the word goes to `fData`/`fVal`.
  - Otherwise: the word goes to `sData`/`sVal`, with `sWrAddr` = `baseAddr` + (w − `FAST_WORDS`), modulo 2^11.
- Bytes arriving after `BYTES` bytes have been received are discarded; no word is emitted. They set the overflow flag.
- On close:
  - `pktDone` pulses if the byte count equals `BYTES` and there is no overflow.
  - Otherwise `pktErr` pulses and `errCnt` increments unless it is already 255.
  - An unpaired trailing high byte (odd count) is dropped.
- The byte counter is 5 bits and holds at `BYTES`; the overflow flag records any excess bytes.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and the counters and flags are cleared.
- Word latency: `fVal`/`sVal` is asserted 1 cycle after the `strob` of the word's low byte. The data and address registers hold until the next word.
- Close latency: if the last `strob` is in cycle T, `pktDone`/`pktErr` is asserted in cycle T+`GAP_CYC`+1.
- A `strob` arriving in the same cycle the timer would expire keeps the packet open: the strobe wins and the timer clears.
- A `strob` in the cycle after the close pulse opens a new packet normally.
- `fVal` and `sVal` are never high in the same cycle.
- `pktDone` and `pktErr` are mutually exclusive.
- The close pulse never coincides with a word pulse of the same packet.
- Reset asserted mid-packet returns the block to IDLE immediately:
  - no close pulse is generated;
  - a partially collected packet is discarded;
  - `errCnt` is cleared.

## Test plan
- Full packet: `BYTES`=16, `FAST_WORDS`=4, `sAddr`=100, bytes 0x01,0x23,0x02,0x34,… with 167-clock spacing.
  - Required: fast words 0x123, 0x234, … on four `fVal` pulses.
  - Required: four `sVal` pulses with `sWrAddr` 100..103.
  - Required: `pktDone` at last strobe + 401 cycles; `errCnt`=0.
- High-nibble masking: high byte 0xF5, low byte 0xAA -> word 0x5AA.
- Short packet of 10 bytes:
  - Required: 5 words emitted (4 fast, 1 slow at address 100).
  - Required: `pktErr` pulse; `errCnt`=1; no `pktDone`.
- Overflow, 18 bytes:
  - Required: exactly 8 words emitted; bytes 17–18 produce no pulse.
  - Required: `pktErr`; `errCnt` increments.
- Gap boundary:
  - Inter-byte idle of `GAP_CYC`−1 cycles, or a strobe coinciding with expiry -> a single packet.
  - Idle of `GAP_CYC` cycles -> two packets, each flagged `pktErr`.
- Reset and saturation:
  - `rst` after 7 bytes -> all outputs 0 and no close pulse; the next full packet yields `pktDone`.
  - 260 short packets -> `errCnt` holds at 255.
- Address wrap: `sAddr`=2046 -> `sWrAddr` sequence 2046, 2047, 0, 1.
